// File: rtl/fb_scanout_reader_if.sv
// Bus bundle for fb_scanout_reader: the SRAM read port toward the shared
// arbiter and the pixel port toward the video output stage.
//
// Handshakes:
//   SRAM read: oMEM_READ is held high with a stable oMEM_ADDR until the
//   arbiter answers with iMEM_GRANT. A read is accepted exactly on the cycles
//   where oMEM_READ && iMEM_GRANT. Its data shows up on iMEM_DATA a fixed
//   READ_LAT cycles later.
//   Pixel: oPIX_VALID/oPIX_DATA present the FIFO head. A pixel is taken on the
//   cycles where iPIX_REQ && oPIX_VALID. iPIX_REQ while oPIX_VALID is low is an
//   underflow.
interface fb_scanout_reader_if;
  logic        iFRAME_START;
  logic [17:0] oMEM_ADDR;
  logic        oMEM_READ;
  logic        iMEM_GRANT;
  logic [15:0] iMEM_DATA;
  logic        iPIX_REQ;
  logic [15:0] oPIX_DATA;
  logic        oPIX_VALID;
  logic        oFRAME_DONE;
  logic        oUNDERFLOW;

  // Reader side.
  modport master (
    input  iFRAME_START, iMEM_GRANT, iMEM_DATA, iPIX_REQ,
    output oMEM_ADDR, oMEM_READ, oPIX_DATA, oPIX_VALID, oFRAME_DONE, oUNDERFLOW
  );

  // Environment side: arbiter, memory and video stage.
  modport slave (
    output iFRAME_START, iMEM_GRANT, iMEM_DATA, iPIX_REQ,
    input  oMEM_ADDR, oMEM_READ, oPIX_DATA, oPIX_VALID, oFRAME_DONE, oUNDERFLOW
  );
endinterface

// File: rtl/fb_scanout_reader.sv
// Framebuffer scan-out reader. Walks the frame in raster order, reads pixels
// through the SRAM arbiter, and buffers them in a prefetch FIFO for the video
// stage. Addresses follow the writer's y*LINE_STRIDE + x layout and are built
// incrementally, so there is no multiplier.
// Optional 2x pixel/line doubling is enabled with `define FB_SCANOUT_PIXDOUBLE_EN.
module fb_scanout_reader #(
  parameter int H_ACTIVE    = 320,
  parameter int V_ACTIVE    = 240,
  parameter int LINE_STRIDE = 640,
  parameter int READ_LAT    = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                iCLK,
  input  logic                iRST,
  fb_scanout_reader_if.master bus,
  output logic [1:0]          dbg_state
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = 18;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [AW-1:0]     line_base_q;
  logic [READ_LAT-1:0] pipe_q;
  logic [CW-1:0]     inflight_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [15:0]       last_q;
  logic              underflow_q;

  logic mem_read, frame_done, credit_ok, grant_fire;
  logic x_last, y_last, frame_last;
  logic push, pop, pop_req, valid, flush;

  // A frame start acts like a local reset of the scan and the read path.
  assign flush = bus.iFRAME_START;

  assign x_last = (x_q == XW'(H_ACTIVE - 1));
  assign y_last = (y_q == YW'(V_ACTIVE - 1));

`ifdef FB_SCANOUT_PIXDOUBLE_EN
  logic pass_q;  // second fetch of the current line
  logic half_q;  // head already delivered once
  assign frame_last = x_last && y_last && pass_q;
  assign pop        = pop_req && half_q;
`else
  assign frame_last = x_last && y_last;
  assign pop        = pop_req;
`endif

  // Reads already granted count against FIFO space so returns always fit.
  assign credit_ok  = ((CW+1)'(count_q) + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH);
  assign grant_fire = mem_read && bus.iMEM_GRANT;
  assign push       = pipe_q[READ_LAT-1];
  assign valid      = (count_q != '0);
  assign pop_req    = bus.iPIX_REQ && valid;

  // FSM state register.
  always_ff @(posedge iCLK) begin
    if (iRST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic; a frame start wins from any state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      FETCH:   if (grant_fire && frame_last) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0 && count_q == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = FETCH;
  end

  // FSM outputs: request only while fetching and credit remains.
  always_comb begin
    mem_read   = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      FETCH:   mem_read   = credit_ok;
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  // Raster position; advances only on an accepted read.
  always_ff @(posedge iCLK) begin
    if (iRST || flush) begin
      x_q         <= '0;
      y_q         <= '0;
      line_base_q <= '0;
`ifdef FB_SCANOUT_PIXDOUBLE_EN
      pass_q      <= 1'b0;
`endif
    end else if (grant_fire) begin
      if (x_last) begin
        x_q <= '0;
`ifdef FB_SCANOUT_PIXDOUBLE_EN
        pass_q <= ~pass_q;
        if (pass_q) begin
          y_q         <= y_q + YW'(1);
          line_base_q <= line_base_q + AW'(LINE_STRIDE);
        end
`else
        y_q         <= y_q + YW'(1);
        line_base_q <= line_base_q + AW'(LINE_STRIDE);
`endif
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Return tags and in-flight count; flushing drops any pending returns.
  always_ff @(posedge iCLK) begin
    if (iRST || flush) begin
      pipe_q     <= '0;
      inflight_q <= '0;
    end else begin
      pipe_q[0] <= grant_fire;
      for (int i = 1; i < READ_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      unique case ({grant_fire, push})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // FIFO storage; entries beyond the pointers are don't-care.
  always_ff @(posedge iCLK) begin
    if (push) mem_q[wr_ptr_q] <= bus.iMEM_DATA;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge iCLK) begin
    if (iRST || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef FB_SCANOUT_PIXDOUBLE_EN
      half_q   <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
`ifdef FB_SCANOUT_PIXDOUBLE_EN
      if (pop_req) half_q <= ~half_q;
`endif
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Credit accounting must make overflow impossible.
  always_ff @(posedge iCLK) begin
    if (!iRST && !flush && push && !pop)
      assert (count_q != CW'(FIFO_DEPTH));
  end

  // Last delivered pixel, shown while the FIFO is empty; sticky underflow flag.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      last_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (pop_req) last_q <= mem_q[rd_ptr_q];
      if (flush)                             underflow_q <= 1'b0;
      else if (bus.iPIX_REQ && !valid)       underflow_q <= 1'b1;
    end
  end

  assign bus.oMEM_ADDR   = line_base_q + AW'(x_q);
  assign bus.oMEM_READ   = mem_read;
  assign bus.oPIX_DATA   = valid ? mem_q[rd_ptr_q] : last_q;
  assign bus.oPIX_VALID  = valid;
  assign bus.oFRAME_DONE = frame_done;
  assign bus.oUNDERFLOW  = underflow_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fb_scanout_reader.sv
// Directed bench for fb_scanout_reader on a small 4x3 frame with a 4-entry
// FIFO. A memory model answers every accepted read with addr[15:0] after
// READ_LAT cycles; expected addresses come from a y*640+x table built here.
module tb_fb_scanout_reader;
  localparam int H      = 4;
  localparam int V      = 3;
  localparam int STRIDE = 640;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;
  localparam int NPIX   = H * V;

  // Clock and reset.
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  fb_scanout_reader_if bus();

  fb_scanout_reader #(
    .H_ACTIVE(H), .V_ACTIVE(V), .LINE_STRIDE(STRIDE),
    .READ_LAT(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .iCLK(clk), .iRST(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // Memory model: data = address low bits, READ_LAT cycles after the grant.
  logic [15:0] dpipe [LAT];
  always @(posedge clk) begin
    dpipe[0] <= (bus.oMEM_READ && bus.iMEM_GRANT) ? bus.oMEM_ADDR[15:0] : 16'hdead;
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.iMEM_DATA = dpipe[LAT-1];

  // Scoreboard.
  int          tests = 0;
  int          fails = 0;
  logic [17:0] exp_addr [NPIX];
  logic [15:0] exp_q [$];
  int          g_idx = 0;
  int          pops  = 0;
  logic [1:0]  g_hist = 2'b00;
  logic        req_en = 1'b0;
  logic        req_force = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: one clock cycle, entered and left at a falling edge.
  task automatic cycle();
    logic [15:0] e;
    bus.iPIX_REQ = req_force | (req_en & bus.oPIX_VALID);
    #1;
    g_hist = {g_hist[0], bus.oMEM_READ & bus.iMEM_GRANT};
    if (bus.oMEM_READ && bus.iMEM_GRANT) begin
      if (g_idx < NPIX) begin
        check("grant_addr", 32'(bus.oMEM_ADDR), 32'(exp_addr[g_idx]));
        e = exp_addr[g_idx][15:0];
        exp_q.push_back(e);
      end else begin
        check("grant_overrun", g_idx, NPIX - 1);
      end
      g_idx++;
    end
    if (bus.iPIX_REQ && bus.oPIX_VALID) begin
      if (exp_q.size() == 0) check("pop_without_expected", exp_q.size(), 1);
      else check("pix_data", 32'(bus.oPIX_DATA), 32'(exp_q.pop_front()));
      pops++;
    end
    @(negedge clk);
  endtask

  task automatic start_frame();
    bus.iFRAME_START = 1'b1;
    cycle();
    bus.iFRAME_START = 1'b0;
    exp_q.delete();
    g_idx = 0;
    pops  = 0;
  endtask

  task automatic run_to_done(input int bound);
    int n = 0;
    while (!bus.oFRAME_DONE && n < bound) begin
      cycle();
      n++;
    end
    check("frame_done", 32'(bus.oFRAME_DONE), 1);
    check("frame_grants", g_idx, NPIX);
    check("frame_pops", pops, NPIX);
  endtask

  initial begin
    int n;
    int lat;
    int saw;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        exp_addr[y*H + x] = 18'(y*STRIDE + x);

    rst              = 1'b1;
    bus.iFRAME_START = 1'b0;
    bus.iMEM_GRANT   = 1'b0;
    bus.iPIX_REQ     = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_addr",      32'(bus.oMEM_ADDR), 0);
    check("rst_read",      32'(bus.oMEM_READ), 0);
    check("rst_pix_data",  32'(bus.oPIX_DATA), 0);
    check("rst_pix_valid", 32'(bus.oPIX_VALID), 0);
    check("rst_done",      32'(bus.oFRAME_DONE), 0);
    check("rst_underflow", 32'(bus.oUNDERFLOW), 0);
    check("rst_state",     32'(dbg_state), 0);

    // Idle without a frame start: no reads.
    rst = 1'b0;
    saw = 0;
    repeat (20) begin
      if (bus.oMEM_READ) saw++;
      cycle();
    end
    check("idle_no_read", saw, 0);
    check("idle_state", 32'(dbg_state), 0);

    // Frame 1: address order, first-valid latency, completion.
    bus.iMEM_GRANT = 1'b1;
    start_frame();
    lat = 1;
    while (!bus.oPIX_VALID && lat < 20) begin
      cycle();
      lat++;
    end
    check("first_valid_latency", lat, LAT + 2);
    req_en = 1'b1;
    run_to_done(200);
    check("done_state", 32'(dbg_state), 3);
    check("f1_underflow", 32'(bus.oUNDERFLOW), 0);
    repeat (5) cycle();
    check("done_no_read", 32'(bus.oMEM_READ), 0);
    check("done_no_extra_grant", g_idx, NPIX);

    // Frame 2: grant stall at address 642.
    start_frame();
    n = 0;
    while (!(bus.oMEM_READ && bus.oMEM_ADDR == 18'd642) && n < 50) begin
      cycle();
      n++;
    end
    check("stall_reach_642", 32'(bus.oMEM_ADDR), 642);
    bus.iMEM_GRANT = 1'b0;
    repeat (5) begin
      check("stall_read_held", 32'(bus.oMEM_READ), 1);
      check("stall_addr_held", 32'(bus.oMEM_ADDR), 642);
      cycle();
    end
    bus.iMEM_GRANT = 1'b1;
    run_to_done(200);
    check("f2_underflow", 32'(bus.oUNDERFLOW), 0);

    // Frame 3: backpressure on the pixel side.
    req_en = 1'b0;
    start_frame();
    repeat (40) cycle();
    check("bp_grants", g_idx, DEPTH);
    check("bp_read_stopped", 32'(bus.oMEM_READ), 0);
    check("bp_valid", 32'(bus.oPIX_VALID), 1);
    check("bp_state", 32'(dbg_state), 1);
    req_en = 1'b1;
    run_to_done(200);

    // Frame 4: underflow before the first valid pixel.
    req_en = 1'b0;
    start_frame();
    req_force = 1'b1;
    cycle();
    cycle();
    req_force = 1'b0;
    check("uf_set", 32'(bus.oUNDERFLOW), 1);
    check("uf_data_held", 32'(bus.oPIX_DATA), 32'h0503);
    check("uf_no_valid", 32'(bus.oPIX_VALID), 0);
    check("uf_no_pop", pops, 0);
    req_en = 1'b1;
    n = 0;
    while (pops < 3 && n < 50) begin
      cycle();
      n++;
    end
    check("pre_restart_pops", pops, 3);
    check("uf_sticky", 32'(bus.oUNDERFLOW), 1);
    check("restart_two_inflight", 32'(g_hist), 3);

    // Mid-frame restart: in-flight returns are dropped.
    start_frame();
    check("restart_uf_cleared", 32'(bus.oUNDERFLOW), 0);
    check("restart_flushed", 32'(bus.oPIX_VALID), 0);
    check("restart_addr0", 32'(bus.oMEM_ADDR), 0);
    n = 0;
    while (!bus.oPIX_VALID && n < 20) begin
      cycle();
      n++;
    end
    check("restart_first_pix", 32'(bus.oPIX_DATA), 0);
    run_to_done(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
- Read-side counterpart of the GPU pixel writer; the writer stores pixel color at SRAM word address y*LINE_STRIDE + x.
- Walks the framebuffer in raster order and issues SRAM read requests through the shared SRAM arbiter.
- Buffers the returned 16-bit pixels in a small prefetch FIFO.
- Hands pixels to the video output stage one per request, so the display reads what the rasterizer wrote.

Parameters:
- H_ACTIVE, 320, visible pixels per line.
- V_ACTIVE, 240, visible lines per frame.
- LINE_STRIDE, 640, word-address distance between consecutive lines; matches the writer's y*640+x mapping.
- READ_LAT, 2, fixed cycles from granted request to iMEM_DATA valid; legal range 1..4.
- FIFO_DEPTH, 16, prefetch FIFO entries; power of two, at least 4.

Ports:
- iCLK  in  1  system clock.
- iRST  in  1  synchronous active-high reset.
- iFRAME_START  in  1  one-cycle pulse; restart scan at (0,0) and flush the FIFO.
- oMEM_ADDR  out  18  SRAM word address of the current read request.
- oMEM_READ  out  1  read request; held until granted.
- iMEM_GRANT  in  1  arbiter accepts the request this cycle; may be low while GPU writes have priority.
- iMEM_DATA  in  16  read data, valid READ_LAT cycles after each granted request.
- iPIX_REQ  in  1  video stage consumes one pixel this cycle.
- oPIX_DATA  out  16  pixel at the FIFO head.
- oPIX_VALID  out  1  FIFO non-empty.
- oFRAME_DONE  out  1  every pixel of the frame has been requested and delivered.
- oUNDERFLOW  out  1  sticky; iPIX_REQ arrived while oPIX_VALID was low.

Behaviour:
- Reset values: oMEM_ADDR=0, oMEM_READ=0, oPIX_DATA=0, oPIX_VALID=0, oFRAME_DONE=0, oUNDERFLOW=0, state IDLE, x=y=0, FIFO empty, in-flight=0.
- Reset is synchronous and overrides every other input, including reads in flight. Data returning after reset is discarded via the flushed return pipe.
- States:
  - IDLE: wait for iFRAME_START, then go to FETCH.
  - FETCH: issue reads; after the last granted address (x=H_ACTIVE-1, y=V_ACTIVE-1), go to DRAIN.
  - DRAIN: wait until in-flight=0 and the FIFO is empty, then go to DONE.
  - DONE: hold oFRAME_DONE=1; iFRAME_START returns to FETCH.
- Address rule: oMEM_ADDR = y*LINE_STRIDE + x, in 18-bit arithmetic. Maintain it incrementally: +1 within a line; at line end, line_base += LINE_STRIDE and x=0. No multiplier in the request path.
- Credit rule: oMEM_READ=1 only in FETCH, and only when fifo_count + inflight < FIFO_DEPTH.
- Request hold: a request with oMEM_READ=1 and iMEM_GRANT=0 keeps the same address. x/y advance only on the cycle read&&grant is true.
- Return pipe: a READ_LAT-deep valid shift register tags each granted request. When the tag exits the pipe, iMEM_DATA is pushed into the FIFO. The FIFO never overflows by construction; an overflow is an assertion failure.
- Output handshake: oPIX_DATA/oPIX_VALID present the FIFO head, first-word-fall-through, and the head pops on iPIX_REQ && oPIX_VALID.
- Simultaneous events: push and pop in the same cycle leave the count unchanged. Grant and return in the same cycle leave in-flight unchanged.
- Underflow: iPIX_REQ with the FIFO empty sets oUNDERFLOW. Nothing pops, and oPIX_DATA holds its last value. oUNDERFLOW clears only on iRST or iFRAME_START.
- iFRAME_START in any state:
  - x=y=line_base=0.
  - FIFO count=0; the return pipe is cleared, so in-flight data is dropped and in-flight=0.
  - oFRAME_DONE=0; state FETCH.
  - The first new request appears the following cycle.
- Latency: from iFRAME_START with constant grant, the first oPIX_VALID rises READ_LAT+2 cycles later.
- A full frame is exactly H_ACTIVE*V_ACTIVE granted reads and H_ACTIVE*V_ACTIVE pops.

Optional Feature:
- Macro: FB_SCANOUT_PIXDOUBLE_EN.
- Defined: the output is doubled for 2x scale-up to a 640x480 display.
  - Each FIFO entry is delivered on two consecutive pops; the head pops on the second iPIX_REQ.
  - Each line is fetched twice: y advances only every second line pass, and the x sequence repeats.
  - The frame completes after 4*H_ACTIVE*V_ACTIVE pops and 2*H_ACTIVE*V_ACTIVE reads.
- Undefined: one pop per pixel, one fetch per line; no extra logic is generated.

Test Plan:
- Reset and idle: iRST held 3 cycles -> all outputs 0; no oMEM_READ for 20 cycles without iFRAME_START.
- Address sequence: H_ACTIVE=4, V_ACTIVE=3, constant grant, memory model returns data=addr[15:0] -> granted addresses 0,1,2,3,640,641,642,643,1280..1283; pixels pop in that order; oFRAME_DONE rises after the 12th pop.
- Grant stall: grant low for 5 cycles mid-line at address 642 -> oMEM_READ held, oMEM_ADDR stays 642, no duplicate or skipped pixel.
- Backpressure: iPIX_REQ low for 40 cycles -> requests stop with exactly FIFO_DEPTH entries buffered plus in flight, never over; releasing iPIX_REQ resumes reads without loss.
- Underflow: iPIX_REQ asserted before the first valid -> oUNDERFLOW=1, FIFO pops nothing; iFRAME_START clears it.
- Mid-frame restart: iFRAME_START while 2 reads are in flight -> those returns are dropped; the next pixel popped equals data from address 0.
